// File: rtl/grid_move_engine_if.sv
// grid_move_engine_if: command, debug-write and grid/score status bundle between game controller and move engine.
interface grid_move_engine_if #(
    parameter int SCORE_W = 20
);
    logic               cmd_valid;
    logic [2:0]         cmd;
    logic               cmd_ready;
    logic               wr_en;
    logic [1:0]         wr_x;
    logic [1:0]         wr_y;
    logic [5:0]         wr_val;
    logic [95:0]        grid_flat;
    logic [SCORE_W-1:0] score;
    logic               moved;
    logic               done;
    logic               game_over;
    modport master (
        output cmd_valid, cmd, wr_en, wr_x, wr_y, wr_val,
        input  cmd_ready, grid_flat, score, moved, done, game_over
    );
    modport slave (
        input  cmd_valid, cmd, wr_en, wr_x, wr_y, wr_val,
        output cmd_ready, grid_flat, score, moved, done, game_over
    );
endinterface

// File: rtl/grid_move_engine.sv
// grid_move_engine: 4x4 slide/merge game engine with LFSR tile spawn, saturating score and game-over detection.
module grid_move_engine #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          SCORE_W   = 20
) (
    input logic               iCLK,
    input logic               iRST_N,
    grid_move_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, SLIDE, SPAWN, CHECK} state_t;

    state_t             state_q, state_d;
    logic [15:0][5:0]   grid_q, grid_d;
    logic [SCORE_W-1:0] score_q, score_d, score_slide;
    logic [15:0]        lfsr_q;
    logic [1:0]         dir_q, dir_d, line_q, line_d;
    logic [3:0]         probe_q, probe_d, cnt_q, cnt_d, p;
    logic               first_q, first_d, extra_q, extra_d, busy_q, busy_d;
    logic               acc_q, acc_d, moved_q, moved_d, done_q, done_d, go_q, go_d;
    logic [3:0][5:0]    line_in, line_out;
    logic [4:0][5:0]    c;
    logic [SCORE_W+1:0] add, sum;
    logic               sat, skip, full, pair, spawn_end;
    logic [2:0]         n, m;

    // Element k of line l, destination first; cell index is {y, x}.
    function automatic logic [3:0] cell_idx(input logic [1:0] d, input logic [1:0] l, input logic [1:0] k);
        logic [1:0] q;
        q = d[0] ? ~k : k;
        return d[1] ? {q, l} : {l, q};
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) line_in[k] = grid_q[cell_idx(dir_q, line_q, 2'(k))];
        c = '0;
        n = '0;
        for (int k = 0; k < 4; k++)
            if (line_in[k] != '0) begin
                c[n] = line_in[k];
                n = n + 3'd1;
            end
        line_out = '0;
        m = '0;
        skip = 1'b0;
        add = '0;
        sat = 1'b0;
        // c[4] is always empty, so the last tile never finds a partner
        for (int k = 0; k < 4; k++)
            if (skip) skip = 1'b0;
            else if (c[k] != '0) begin
                if (c[k] == c[k+1] && c[k] != 6'd63) begin
                    line_out[m[1:0]] = c[k] + 6'd1;
                    if (int'(c[k]) + 1 >= SCORE_W) sat = 1'b1;
                    else add = add + ((SCORE_W+2)'(1) << (c[k] + 6'd1));
                    skip = 1'b1;
                end else line_out[m[1:0]] = c[k];
                m = m + 3'd1;
            end
        sum = {2'b00, score_q} + add;
        score_slide = (sat || sum[SCORE_W+1:SCORE_W] != 2'b00) ? '1 : sum[SCORE_W-1:0];
    end

    always_comb begin
        full = 1'b1;
        pair = 1'b0;
        for (int i = 0; i < 16; i++) full = full & (grid_q[i] != '0);
        for (int i = 0; i < 12; i++) pair = pair | (grid_q[i] == grid_q[i+4]);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 3; x++) pair = pair | (grid_q[4*y+x] == grid_q[4*y+x+1]);
    end

    always_comb begin
        state_d = state_q;
        grid_d = grid_q;
        score_d = score_q;
        dir_d = dir_q;
        line_d = line_q;
        probe_d = probe_q;
        cnt_d = cnt_q;
        first_d = first_q;
        extra_d = extra_q;
        busy_d = busy_q;
        acc_d = acc_q;
        moved_d = moved_q;
        go_d = go_q;
        done_d = 1'b0;
        spawn_end = 1'b0;
        p = first_q ? lfsr_q[3:0] : probe_q;
        case (state_q)
            IDLE:
                if (bus.cmd_valid) begin
                    busy_d = 1'b1;
                    dir_d = bus.cmd[1:0];
                    line_d = '0;
                    acc_d = 1'b0;
                    state_d = !bus.cmd[2] ? SLIDE : (bus.cmd[1:0] == 2'd0 ? CLEAR : CHECK);
                end else if (bus.wr_en) begin
                    grid_d[{bus.wr_y, bus.wr_x}] = bus.wr_val;
                    busy_d = 1'b0;
                    state_d = CHECK;
                end
            CLEAR: begin
                grid_d = '0;
                score_d = '0;
                acc_d = 1'b1;
                extra_d = 1'b1;
                first_d = 1'b1;
                cnt_d = '0;
                state_d = SPAWN;
            end
            SLIDE: begin
                for (int k = 0; k < 4; k++) grid_d[cell_idx(dir_q, line_q, 2'(k))] = line_out[k];
                score_d = score_slide;
                acc_d = acc_q | (line_out != line_in);
                line_d = line_q + 2'd1;
                first_d = 1'b1;
                cnt_d = '0;
                extra_d = 1'b0;
                if (line_q == 2'd3) state_d = acc_d ? SPAWN : CHECK;
            end
            SPAWN: begin
                if (grid_q[p] == '0) begin
                    grid_d[p] = lfsr_q[7:5] == 3'd0 ? 6'd2 : 6'd1;
                    spawn_end = 1'b1;
                end else spawn_end = cnt_q == 4'd15;
                probe_d = p + 4'd1;
                first_d = spawn_end;
                cnt_d = spawn_end ? '0 : cnt_q + 4'd1;
                if (spawn_end) begin
                    extra_d = 1'b0;
                    state_d = extra_q ? SPAWN : CHECK;
                end
            end
            CHECK: begin
                go_d = full & ~pair;
                done_d = busy_q;
                moved_d = busy_q ? acc_q : moved_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) begin
            state_q <= IDLE;
            grid_q <= '0;
            score_q <= '0;
            lfsr_q <= LFSR_SEED;
            dir_q <= '0;
            line_q <= '0;
            probe_q <= '0;
            cnt_q <= '0;
            first_q <= 1'b0;
            extra_q <= 1'b0;
            busy_q <= 1'b0;
            acc_q <= 1'b0;
            moved_q <= 1'b0;
            done_q <= 1'b0;
            go_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q <= grid_d;
            score_q <= score_d;
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            dir_q <= dir_d;
            line_q <= line_d;
            probe_q <= probe_d;
            cnt_q <= cnt_d;
            first_q <= first_d;
            extra_q <= extra_d;
            busy_q <= busy_d;
            acc_q <= acc_d;
            moved_q <= moved_d;
            done_q <= done_d;
            go_q <= go_d;
        end

    assign bus.cmd_ready = state_q == IDLE;
    assign bus.grid_flat = grid_q;
    assign bus.score = score_q;
    assign bus.moved = moved_q;
    assign bus.done = done_q;
    assign bus.game_over = go_q;
endmodule

// File: tb/tb_grid_move_engine.sv
// tb_grid_move_engine: table-driven move vectors with a done-triggered scoreboard, plus latency, game-over and async-reset sequences.
module tb_grid_move_engine;
    localparam int SW = 20;
    localparam logic [SW-1:0] SMAX = '1;
    localparam logic [23:0] Z = '0;

    typedef struct {
        string       name;
        logic [95:0] gin;
        logic [2:0]  cmd;
        logic [95:0] gexp;
        longint      delta;
        logic        mv;
        int          sp;
    } vec_t;

    typedef struct {
        string         name;
        logic [95:0]   g;
        logic [SW-1:0] sc;
        logic          mv;
        int            sp;
    } exp_t;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    int            passed = 0;
    int            total = 0;
    int            done_cnt = 0;
    logic [SW-1:0] exp_score = '0;
    logic [95:0]   cb;
    exp_t          sb[$];
    vec_t          tv[10];

    grid_move_engine_if #(.SCORE_W(SW)) bus();
    grid_move_engine #(.LFSR_SEED(16'hACE1), .SCORE_W(SW)) dut (.iCLK(iCLK), .iRST_N(iRST_N), .bus(bus));

    always #5 iCLK = ~iCLK;

    function automatic logic [23:0] r(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    function automatic logic [95:0] g(input logic [23:0] r0, input logic [23:0] r1, input logic [23:0] r2, input logic [23:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    task automatic setv(input int i, input string nm, input logic [95:0] gi, input logic [2:0] c,
                        input logic [95:0] ge, input longint d, input logic mv, input int sp);
        tv[i].name = nm;
        tv[i].gin = gi;
        tv[i].cmd = c;
        tv[i].gexp = ge;
        tv[i].delta = d;
        tv[i].mv = mv;
        tv[i].sp = sp;
    endtask

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            if (bus.cmd_ready) return;
            @(posedge iCLK);
            #1;
        end
        total++;
        $display("FAIL ready_timeout actual=0 required=1");
    endtask

    task automatic wr(input logic [1:0] x, input logic [1:0] y, input logic [5:0] v);
        wait_ready();
        bus.wr_en = 1'b1;
        bus.wr_x = x;
        bus.wr_y = y;
        bus.wr_val = v;
        @(posedge iCLK);
        #1 bus.wr_en = 1'b0;
    endtask

    task automatic load(input logic [95:0] gi);
        for (int i = 0; i < 16; i++) wr(2'(i % 4), 2'(i / 4), gi[6*i +: 6]);
    endtask

    task automatic issue(input logic [2:0] c);
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd = c;
        @(posedge iCLK);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // Expected score follows the move delta with saturation; new game restarts it at zero.
    task automatic push(input string nm, input logic [95:0] ge, input logic [2:0] c, input longint d, input logic mv, input int sp);
        exp_t   e;
        longint s;
        s = (c == 3'd4) ? 64'sd0 : longint'(exp_score) + d;
        exp_score = (s > longint'(SMAX)) ? SMAX : SW'(s);
        e.name = nm;
        e.g = ge;
        e.sc = exp_score;
        e.mv = mv;
        e.sp = sp;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) return;
            @(posedge iCLK);
            #1;
        end
        total++;
        $display("FAIL done_timeout pending=%0d required=0", sb.size());
        sb.delete();
    endtask

    // A spawned tile may only appear as exponent 1 or 2 in a cell the move left empty.
    always @(negedge iCLK) begin : mon
        exp_t        e;
        logic [95:0] am;
        int          extra;
        if (iRST_N && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                am = bus.grid_flat;
                extra = 0;
                for (int i = 0; i < 16; i++)
                    if (e.g[6*i +: 6] == 6'd0 && (am[6*i +: 6] == 6'd1 || am[6*i +: 6] == 6'd2)) begin
                        am[6*i +: 6] = 6'd0;
                        extra++;
                    end
                chk({e.name, "_grid"}, am, e.g);
                chk({e.name, "_spawns"}, 96'(extra), 96'(e.sp));
                chk({e.name, "_score"}, 96'(bus.score), 96'(e.sc));
                chk({e.name, "_moved"}, 96'(bus.moved), 96'(e.mv));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        int dc;
        setv(0, "merge",   g(r(1,1,1,1), Z, Z, Z), 3'd0, g(r(2,2,0,0), Z, Z, Z), 64'd8, 1'b1, 1);
        setv(1, "nodbl",   g(r(2,1,1,0), r(0,1,0,1), Z, Z), 3'd1, g(r(0,0,2,2), r(0,0,0,2), Z, Z), 64'd8, 1'b1, 1);
        setv(2, "noop",    g(r(1,2,0,0), Z, Z, Z), 3'd0, g(r(1,2,0,0), Z, Z, Z), 64'd0, 1'b0, 0);
        setv(3, "up",      g(Z, r(3,0,0,0), r(3,0,0,0), r(3,0,0,0)), 3'd2, g(r(4,0,0,0), r(3,0,0,0), Z, Z), 64'd16, 1'b1, 1);
        setv(4, "down",    g(r(0,0,1,0), Z, Z, r(0,0,1,0)), 3'd3, g(Z, Z, Z, r(0,0,2,0)), 64'd4, 1'b1, 1);
        setv(5, "tile63",  g(Z, Z, r(0,63,63,0), Z), 3'd0, g(Z, Z, r(63,63,0,0), Z), 64'd0, 1'b1, 1);
        setv(6, "cmd5",    g(r(1,1,0,0), Z, Z, Z), 3'd5, g(r(1,1,0,0), Z, Z, Z), 64'd0, 1'b0, 0);
        setv(7, "newgame", g(r(3,3,0,0), Z, Z, r(5,0,0,5)), 3'd4, '0, 64'd0, 1'b1, 2);
        setv(8, "right3",  g(Z, r(2,2,2,0), Z, Z), 3'd1, g(Z, r(0,0,2,3), Z, Z), 64'd8, 1'b1, 1);
        setv(9, "sat",     g(r(19,19,0,0), Z, Z, Z), 3'd0, g(r(20,0,0,0), Z, Z, Z), 64'd1 << 20, 1'b1, 1);
        bus.cmd_valid = 1'b0;
        bus.cmd = 3'd0;
        bus.wr_en = 1'b0;
        bus.wr_x = 2'd0;
        bus.wr_y = 2'd0;
        bus.wr_val = 6'd0;
        @(posedge iCLK);
        #1;
        chk("rst_grid", bus.grid_flat, 96'd0);
        chk("rst_score", 96'(bus.score), 96'd0);
        chk("rst_game_over", 96'(bus.game_over), 96'd0);
        chk("rst_done", 96'(bus.done), 96'd0);
        chk("rst_moved", 96'(bus.moved), 96'd0);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
        chk("rst_ready", 96'(bus.cmd_ready), 96'd1);
        for (int i = 0; i < 10; i++) begin
            load(tv[i].gin);
            push(tv[i].name, tv[i].gexp, tv[i].cmd, tv[i].delta, tv[i].mv, tv[i].sp);
            issue(tv[i].cmd);
            wait_done();
        end
        // No-op move: accept cycle T, done must be visible in cycle T+6 (five edges after acceptance)
        load(g(r(1,2,0,0), Z, Z, Z));
        push("noop_lat", g(r(1,2,0,0), Z, Z, Z), 3'd0, 64'd0, 1'b0, 0);
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd = 3'd0;
        @(posedge iCLK);
        #1 bus.cmd_valid = 1'b0;
        chk("ready_drop", 96'(bus.cmd_ready), 96'd0);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge iCLK);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk("noop_latency", 96'(lat), 96'd5);
        wait_done();
        // Checkerboard of 1/2: full grid, no equal neighbours
        cb = '0;
        for (int i = 0; i < 16; i++) cb[6*i +: 6] = (((i % 4) + (i / 4)) % 2 == 1) ? 6'd2 : 6'd1;
        wr(2'd3, 2'd3, 6'd0);
        for (int i = 0; i < 15; i++) wr(2'(i % 4), 2'(i / 4), cb[6*i +: 6]);
        wait_ready();
        chk("go_partial", 96'(bus.game_over), 96'd0);
        bus.wr_x = 2'd3;
        bus.wr_y = 2'd3;
        bus.wr_val = cb[95:90];
        bus.wr_en = 1'b1;
        @(posedge iCLK);
        #1 bus.wr_en = 1'b0;
        chk("go_wait", 96'(bus.game_over), 96'd0);
        @(posedge iCLK);
        #1;
        chk("go_set", 96'(bus.game_over), 96'd1);
        for (int c = 0; c < 4; c++) begin
            push("go_dir", cb, 3'(c), 64'd0, 1'b0, 0);
            issue(3'(c));
            wait_done();
            chk("go_hold", 96'(bus.game_over), 96'd1);
        end
        // Asynchronous reset two edges into a slide
        load(g(r(1,1,0,0), Z, Z, Z));
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd = 3'd0;
        @(posedge iCLK);
        #1 bus.cmd_valid = 1'b0;
        @(posedge iCLK);
        @(posedge iCLK);
        #1;
        chk("busy_before_rst", 96'(bus.cmd_ready), 96'd0);
        #2 iRST_N = 1'b0;
        #1;
        chk("arst_grid", bus.grid_flat, 96'd0);
        chk("arst_score", 96'(bus.score), 96'd0);
        chk("arst_game_over", 96'(bus.game_over), 96'd0);
        chk("arst_ready", 96'(bus.cmd_ready), 96'd1);
        dc = done_cnt;
        repeat (3) @(posedge iCLK);
        #1 iRST_N = 1'b1;
        repeat (20) @(posedge iCLK);
        #1;
        chk("no_done_after_rst", 96'(done_cnt), 96'(dc));
        chk("post_rst_grid", bus.grid_flat, 96'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
